// File: rtl/fft_sample_loader.sv
// Streams one frame of complex samples into the FFT buffer, in natural or
// bit-reversed address order, and then kicks off the FFT engine.
module fft_sample_loader #(
    parameter int unsigned DATA_WIDTH          = 16,
    parameter int unsigned FFT_MAX_LENGTH_LOG2 = 12,
    parameter int unsigned ADDR_WIDTH          = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [3:0]                     cfg_length_log2_i,
    input  logic                           cfg_bitrev_en_i,
    input  logic                           arm_i,
    input  logic                           abort_i,
    input  logic                           s_valid_i,
    output logic                           s_ready_o,
    input  logic [2*DATA_WIDTH-1:0]        s_data_i,
    input  logic                           s_last_i,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    output logic [2*DATA_WIDTH-1:0]        mem_data_o,
    output logic                           mem_write_o,
    input  logic                           mem_ready_i,
    input  logic                           fft_busy_i,
    output logic                           fft_start_o,
    output logic                           busy_o,
    output logic                           frame_done_o,
    output logic                           error_o,
    output logic [FFT_MAX_LENGTH_LOG2:0]   sample_count_o
);

    localparam int unsigned CNT_W = FFT_MAX_LENGTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, START} state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  len_q, len_d;
    logic                        bitrev_q, bitrev_d;
    logic                        suppress_q, suppress_d;
    logic                        error_q, error_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [2*DATA_WIDTH-1:0]     data_q, data_d;
    logic                        wr_q, wr_d;

    logic                        accept;
    logic                        cfg_legal;
    logic                        is_last_idx;
    logic [FFT_MAX_LENGTH_LOG2-1:0] idx_bits, idx_rev;
    logic [ADDR_WIDTH-1:0]       addr_calc;

    assign s_ready_o      = (state_q == LOAD) && (!wr_q || mem_ready_i);
    assign accept         = s_valid_i && s_ready_o && !abort_i;
    assign cfg_legal      = (cfg_length_log2_i >= 4'd8) &&
                            (32'(cfg_length_log2_i) <= FFT_MAX_LENGTH_LOG2);
    assign is_last_idx    = (count_q == CNT_W'((32'd1 << len_q) - 32'd1));

    assign busy_o         = (state_q != IDLE);
    assign fft_start_o    = (state_q == START);
    assign frame_done_o   = (state_q == START);
    assign error_o        = error_q;
    assign sample_count_o = count_q;
    assign mem_addr_o     = addr_q;
    assign mem_data_o     = data_q;
    assign mem_write_o    = wr_q;

    // Write address for the current index: full-width reversal, then shifted
    // down so only the latched L bits take part in the reversal.
    always_comb begin
        idx_bits = count_q[FFT_MAX_LENGTH_LOG2-1:0];
        idx_rev  = '0;
        for (int unsigned i = 0; i < FFT_MAX_LENGTH_LOG2; i++) begin
            idx_rev[i] = idx_bits[FFT_MAX_LENGTH_LOG2-1-i];
        end
        if (bitrev_q) begin
            addr_calc = ADDR_WIDTH'(idx_rev >> (FFT_MAX_LENGTH_LOG2 - 32'(len_q)));
        end else begin
            addr_calc = ADDR_WIDTH'(count_q);
        end
    end

    // Next-state and datapath updates; abort overrides everything else.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        bitrev_d   = bitrev_q;
        suppress_d = suppress_q;
        error_d    = error_q;
        count_d    = count_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = wr_q && !mem_ready_i;

        if (abort_i) begin
            state_d = IDLE;
            wr_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm_i && !fft_busy_i) begin
                        if (cfg_legal) begin
                            len_d      = cfg_length_log2_i;
                            bitrev_d   = cfg_bitrev_en_i;
                            count_d    = '0;
                            error_d    = 1'b0;
                            suppress_d = 1'b0;
                            state_d    = LOAD;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        data_d  = s_data_i;
                        addr_d  = addr_calc;
                        wr_d    = 1'b1;
                        count_d = count_q + 1'b1;
                        if (s_last_i && is_last_idx) begin
                            state_d = DRAIN;
                        end else if (s_last_i || is_last_idx) begin
                            error_d    = 1'b1;
                            suppress_d = 1'b1;
                            state_d    = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Leave as soon as the final write completes this cycle.
                    if (!wr_q || mem_ready_i) begin
                        state_d = suppress_q ? IDLE : START;
                    end
                end
                START: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            bitrev_q   <= 1'b0;
            suppress_q <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            bitrev_q   <= bitrev_d;
            suppress_q <= suppress_d;
            error_q    <= error_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader: stimulus pushes expected buffer
// writes, a negedge monitor pops and compares every completed write.
module tb_fft_sample_loader;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int ML = 12;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [3:0]      cfg_length_log2_i;
    logic            cfg_bitrev_en_i;
    logic            arm_i;
    logic            abort_i;
    logic            s_valid_i;
    logic            s_ready_o;
    logic [2*DW-1:0] s_data_i;
    logic            s_last_i;
    logic [AW-1:0]   mem_addr_o;
    logic [2*DW-1:0] mem_data_o;
    logic            mem_write_o;
    logic            mem_ready_i;
    logic            fft_busy_i;
    logic            fft_start_o;
    logic            busy_o;
    logic            frame_done_o;
    logic            error_o;
    logic [ML:0]     sample_count_o;

    fft_sample_loader #(
        .DATA_WIDTH(DW),
        .FFT_MAX_LENGTH_LOG2(ML),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .cfg_length_log2_i(cfg_length_log2_i),
        .cfg_bitrev_en_i(cfg_bitrev_en_i),
        .arm_i(arm_i),
        .abort_i(abort_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .s_data_i(s_data_i),
        .s_last_i(s_last_i),
        .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o),
        .mem_write_o(mem_write_o),
        .mem_ready_i(mem_ready_i),
        .fft_busy_i(fft_busy_i),
        .fft_start_o(fft_start_o),
        .busy_o(busy_o),
        .frame_done_o(frame_done_o),
        .error_o(error_o),
        .sample_count_o(sample_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [2*DW-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  start_seen = 0;
    int  exp_starts = 0;
    int  hold_0a = -1;
    int  stall_left = 0;
    bit  force_low = 1'b0;
    bit  rdy_random = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference address: index k read out LSB-first into an L-bit value.
    function automatic logic [AW-1:0] ref_addr(int k, int l, bit br);
        int r = 0;
        if (!br) return AW'(k);
        for (int b = 0; b < l; b++) r = r * 2 + ((k >> b) & 1);
        return AW'(r);
    endfunction

    // Buffer-side ready generator.
    initial begin
        mem_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (force_low) mem_ready_i = 1'b0;
            else if (stall_left > 0) begin mem_ready_i = 1'b0; stall_left--; end
            else if (rdy_random) mem_ready_i = ($urandom_range(0, 3) != 0);
            else mem_ready_i = 1'b1;
        end
    end

    // Monitor: completed writes against the scoreboard, hold stability, start pulses.
    initial begin
        logic [AW-1:0]   hold_addr;
        logic [2*DW-1:0] hold_data;
        int              hold;
        bit              prev_start;
        wr_t             e;
        hold = 0;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (fft_start_o === 1'b1 || frame_done_o === 1'b1) begin
                check("start_done_pair", frame_done_o, fft_start_o);
            end
            if (fft_start_o === 1'b1) begin
                start_seen++;
                check("start_single_cycle", prev_start, 1'b0);
            end
            prev_start = (fft_start_o === 1'b1);
            if (mem_write_o === 1'b1) begin
                if (hold > 0) begin
                    check("hold_addr_stable", mem_addr_o, hold_addr);
                    check("hold_data_stable", mem_data_o, hold_data);
                end else begin
                    hold_addr = mem_addr_o;
                    hold_data = mem_data_o;
                end
                if (mem_ready_i) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", mem_addr_o, mem_data_o);
                    end else begin
                        e = sb.pop_front();
                        check("write_addr", mem_addr_o, e.addr);
                        check("write_data", mem_data_o, e.data);
                    end
                    if (mem_addr_o == AW'(16'h000A)) hold_0a = hold + 1;
                    hold = 0;
                end else begin
                    hold++;
                end
            end else begin
                hold = 0;
            end
        end
    end

    task automatic check_reset_vals(string tag);
        check({tag, "_s_ready"}, s_ready_o, 0);
        check({tag, "_mem_write"}, mem_write_o, 0);
        check({tag, "_fft_start"}, fft_start_o, 0);
        check({tag, "_frame_done"}, frame_done_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_error"}, error_o, 0);
        check({tag, "_addr"}, mem_addr_o, 0);
        check({tag, "_data"}, mem_data_o, 0);
        check({tag, "_count"}, sample_count_o, 0);
    endtask

    task automatic arm(int l, bit br);
        cfg_length_log2_i = 4'(l);
        cfg_bitrev_en_i   = br;
        arm_i             = 1'b1;
        @(posedge clk); #1;
        arm_i = 1'b0;
    endtask

    // Sends indices 0..n-1 with s_last on last_at; requests a 3-cycle ready
    // stall on the write of index stall_at and reports how long the next
    // sample waited for s_ready_o.
    task automatic send_frame(int l, bit br, int n, int last_at, bit gaps,
                              int stall_at, output int stall_wait);
        logic [2*DW-1:0] d;
        int w;
        stall_wait = -1;
        for (int k = 0; k < n; k++) begin
            d = $urandom;
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_valid_i = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_valid_i = 1'b1;
            s_data_i  = d;
            s_last_i  = (k == last_at);
            w = 0;
            @(negedge clk);
            while (!s_ready_o && w < 200) begin
                w++;
                @(negedge clk);
            end
            if (!s_ready_o) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: sample %0d never accepted, s_ready_o=%0b required 1", k, s_ready_o);
                s_valid_i = 1'b0;
                s_last_i  = 1'b0;
                return;
            end
            if (k == stall_at) stall_left = 3;
            if (k == stall_at + 1) stall_wait = w;
            sb.push_back('{addr: ref_addr(k, l, br), data: d});
            @(posedge clk); #1;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic wait_start(int bound, output int cycles);
        cycles = 0;
        while (cycles < bound) begin
            @(negedge clk);
            cycles++;
            if (fft_start_o) break;
        end
        if (!fft_start_o) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: fft_start_o=%0b after %0d cycles, required 1", fft_start_o, cycles);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(int bound);
        int c = 0;
        @(negedge clk);
        while (busy_o && c < bound) begin
            c++;
            @(negedge clk);
        end
        check("idle_reached", busy_o, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int w, lat, snap, l, n;
        bit br;
        reset_i = 1'b1; cfg_length_log2_i = 4'd8; cfg_bitrev_en_i = 1'b0;
        arm_i = 1'b0; abort_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
        s_last_i = 1'b0; fft_busy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset_i = 1'b0;

        // 256-point bit-reversed frame, back to back
        arm(8, 1);
        check("t1_busy", busy_o, 1);
        check("t1_count_cleared", sample_count_o, 0);
        send_frame(8, 1, 256, 255, 0, -1, w);
        exp_starts++;
        wait_start(50, lat);
        check("t1_start_latency", lat, 2);
        check("t1_count", sample_count_o, 256);
        check("t1_busy_after", busy_o, 0);
        check("t1_error", error_o, 0);
        check("t1_sb_empty", sb.size(), 0);

        // natural order with a ready stall on sample 10
        hold_0a = -1;
        arm(8, 0);
        send_frame(8, 0, 256, 255, 0, 10, w);
        check("t2_sample11_wait", w, 3);
        exp_starts++;
        wait_start(50, lat);
        check("t2_hold_0a", hold_0a, 4);
        check("t2_count", sample_count_o, 256);
        check("t2_sb_empty", sb.size(), 0);

        // arm ignored while engine busy, then illegal lengths
        fft_busy_i = 1'b1;
        arm(8, 0);
        check("t4_busy_ignored", busy_o, 0);
        check("t4_err_ignored", error_o, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_still_idle", busy_o, 0);
        fft_busy_i = 1'b0;
        arm(13, 0);
        check("t4_len13_error", error_o, 1);
        check("t4_len13_busy", busy_o, 0);
        check("t4_len13_count_held", sample_count_o, 256);
        arm(7, 1);
        check("t4_len7_error", error_o, 1);
        check("t4_len7_busy", busy_o, 0);
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        check("t4_abort_keeps_error", error_o, 1);

        // early s_last on index 100
        snap = start_seen;
        arm(8, 1);
        check("t3_arm_clears_error", error_o, 0);
        send_frame(8, 1, 101, 100, 0, -1, w);
        wait_idle(20);
        check("t3_error", error_o, 1);
        check("t3_count", sample_count_o, 101);
        check("t3_write100_issued", sb.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        check("t3_no_start", start_seen, snap);

        // missing s_last on index 255
        arm(8, 0);
        send_frame(8, 0, 256, -1, 0, -1, w);
        wait_idle(20);
        check("t3b_error", error_o, 1);
        check("t3b_count", sample_count_o, 256);
        check("t3b_sb_empty", sb.size(), 0);
        check("t3b_no_start", start_seen, snap);

        // abort + arm with a pending write
        force_low = 1'b1;
        arm(8, 1);
        send_frame(8, 1, 1, -1, 0, -1, w);
        @(posedge clk); #1;
        check("t5_write_pending", mem_write_o, 1);
        abort_i = 1'b1; arm_i = 1'b1; s_valid_i = 1'b1; s_data_i = $urandom;
        @(posedge clk); #1;
        abort_i = 1'b0; arm_i = 1'b0; s_valid_i = 1'b0;
        check("t5_idle", busy_o, 0);
        check("t5_write_dropped", mem_write_o, 0);
        check("t5_no_start", fft_start_o, 0);
        check("t5_error_kept", error_o, 0);
        sb.delete();
        force_low = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("t5_arm_overridden", busy_o, 0);
        check("t5_no_start_later", start_seen, snap);

        // abort beats a sample presented in the same cycle
        arm(8, 0);
        send_frame(8, 0, 5, -1, 0, -1, w);
        abort_i = 1'b1; s_valid_i = 1'b1; s_data_i = $urandom;
        @(posedge clk); #1;
        abort_i = 1'b0; s_valid_i = 1'b0;
        check("t5b_count", sample_count_o, 5);
        check("t5b_write_clear", mem_write_o, 0);
        check("t5b_sb_empty", sb.size(), 0);

        // reset at sample 50
        arm(8, 1);
        send_frame(8, 1, 50, -1, 0, -1, w);
        s_valid_i = 1'b1; s_data_i = $urandom; reset_i = 1'b1;
        @(posedge clk); #1;
        s_valid_i = 1'b0;
        check_reset_vals("t6");
        check("t6_sb_empty", sb.size(), 0);
        reset_i = 1'b0;
        arm(8, 1);
        send_frame(8, 1, 256, 255, 0, -1, w);
        exp_starts++;
        wait_start(50, lat);
        check("t6_reload_count", sample_count_o, 256);

        // randomized frames, cfg scrambled after arm
        rdy_random = 1'b1;
        for (int i = 0; i < 3; i++) begin
            l  = (i == 0) ? 9 : ((i == 1) ? 12 : 8);
            br = 1'($urandom);
            n  = 1 << l;
            arm(l, br);
            cfg_length_log2_i = 4'($urandom);
            cfg_bitrev_en_i   = ~br;
            send_frame(l, br, n, n - 1, 1, -1, w);
            exp_starts++;
            wait_start(500, lat);
            check("rnd_count", sample_count_o, 64'(n));
            check("rnd_error", error_o, 0);
            check("rnd_sb_empty", sb.size(), 0);
        end
        rdy_random = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("total_starts", start_seen, exp_starts);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_sample_loader.md
FFT_SAMPLE_LOADER -- requirements
Module: fft_sample_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning per-component (real/imag) sample width.
REQ-002 SHALL have parameter FFT_MAX_LENGTH_LOG2, default 12, meaning largest supported frame log2 length.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, meaning FFT buffer address width.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports clk_i and reset_i.
REQ-005 SHALL have ports, listed as name, direction, width, meaning:
- clk_i, in, 1, system clock, rising edge.
- reset_i, in, 1, synchronous active-high reset.
- cfg_length_log2_i, in, 4, frame length log2; legal range 8..FFT_MAX_LENGTH_LOG2.
- cfg_bitrev_en_i, in, 1, 1 = bit-reversed write addressing, 0 = natural order.
- arm_i, in, 1, single-cycle pulse that starts loading one frame.
- abort_i, in, 1, single-cycle pulse that abandons the current frame.
- s_valid_i, in, 1, sample stream valid.
- s_ready_o, out, 1, sample stream ready.
- s_data_i, in, 2*DATA_WIDTH, sample as {imag, real}.
- s_last_i, in, 1, marks the final sample of the frame.
- mem_addr_o, out, ADDR_WIDTH, FFT buffer write address.
- mem_data_o, out, 2*DATA_WIDTH, FFT buffer write data.
- mem_write_o, out, 1, write request; held until mem_ready_i.
- mem_ready_i, in, 1, buffer accepts the write this cycle.
- fft_busy_i, in, 1, FFT engine busy.
- fft_start_o, out, 1, single-cycle engine start pulse.
- busy_o, out, 1, high whenever state is not IDLE.
- frame_done_o, out, 1, single-cycle pulse when a frame loads successfully.
- error_o, out, 1, sticky error flag.
- sample_count_o, out, FFT_MAX_LENGTH_LOG2+1, number of samples accepted in the current frame.

Function
REQ-006 SHALL implement the states IDLE, LOAD, DRAIN and START.
REQ-007 In IDLE, when arm_i=1, abort_i=0 and fft_busy_i=0, SHALL do the following:
- If cfg_length_log2_i is legal: latch the length and cfg_bitrev_en_i, clear sample_count_o and error_o, and go to LOAD.
- Otherwise: set error_o and stay in IDLE.
REQ-008 In IDLE, SHALL ignore arm_i while fft_busy_i=1 (no state change, no error).
REQ-009 SHALL drive s_ready_o = (state==LOAD) && (!mem_write_o || mem_ready_i), combinationally.
REQ-010 On each accepted sample (s_valid_i && s_ready_o), SHALL perform the following on the next edge:
- Register mem_data_o = s_data_i.
- Register mem_addr_o = address of index k = sample_count_o.
- Set mem_write_o=1.
- Increment sample_count_o.
REQ-011 The address for index k SHALL be the bit-reversal of k over exactly L latched bits when bit-reversal is enabled, otherwise k, zero-extended to ADDR_WIDTH.
REQ-012 SHALL hold mem_write_o, mem_addr_o and mem_data_o stable until mem_ready_i=1, then clear mem_write_o unless a new sample is accepted in the same cycle.
REQ-013 SHALL sustain throughput of one sample per cycle while mem_ready_i stays high.
REQ-014 When the accepted sample is index 2^L-1 and has s_last_i=1, SHALL go to DRAIN.
REQ-015 When s_last_i=1 on index < 2^L-1, or s_last_i=0 on index 2^L-1, SHALL perform the following:
- Still issue that write.
- Set error_o.
- Go to DRAIN with a flag that suppresses the start.
REQ-016 In DRAIN, SHALL deassert s_ready_o and wait until mem_write_o=0, then:
- Go to START if no error occurred.
- Go to IDLE if the error flag is set.
REQ-017 In START, SHALL assert fft_start_o and frame_done_o for exactly one cycle, then return to IDLE.
REQ-018 abort_i SHALL, in any state, perform the following on the next edge:
- Return to IDLE.
- Clear mem_write_o, dropping any pending write.
- Not assert fft_start_o.
- Leave error_o unchanged.
REQ-019 abort_i SHALL take priority over arm_i, sample acceptance and all state transitions in the same cycle.
REQ-020 sample_count_o SHALL never exceed 2^L; it holds its value in IDLE until the next successful arm.
REQ-021 Configuration changes on cfg_* after arm SHALL have no effect until the next arm.

Reset
REQ-022 On reset_i=1 at a clock edge, SHALL set:
- state = IDLE.
- s_ready_o=0, mem_write_o=0, fft_start_o=0, frame_done_o=0, busy_o=0, error_o=0.
- mem_addr_o=0, mem_data_o=0, sample_count_o=0.
REQ-023 A reset asserted mid-frame SHALL discard the frame and any pending write without producing fft_start_o.

Verification
REQ-024 Bench SHALL cover: L=8, bitrev=1, 256 back-to-back samples with last on the final one and mem_ready_i=1 -> addresses 0x00, 0x80, 0x40, 0xC0 …, 0xFF; fft_start_o pulses 2 cycles after the last acceptance; sample_count_o=256.
REQ-025 Bench SHALL cover: L=8, bitrev=0, mem_ready_i low for 3 cycles at sample 10 -> s_ready_o low; addr 0x0A and its data held for 4 cycles; no samples lost.
REQ-026 Bench SHALL cover: s_last_i=1 on sample 100 of a 256-point frame -> error_o=1, write 100 issued, no fft_start_o, return to IDLE.
REQ-027 Bench SHALL cover: arm_i with cfg_length_log2_i=13 -> error_o=1, busy_o stays 0; arm_i with fft_busy_i=1 -> no response.
REQ-028 Bench SHALL cover: abort_i and arm_i in the same cycle during LOAD with a write pending -> IDLE, mem_write_o=0 next cycle, no fft_start_o.
REQ-029 Bench SHALL cover: reset_i pulsed at sample 50 -> all outputs return to reset values next cycle; a following frame loads correctly from sample 0.
